// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//   Instruction-memory request/response bus used by the fetch stage.
//   imem_req   : request valid, held until acknowledged
//   imem_addr  : request address, stable while imem_req=1 and imem_ack=0
//   imem_ack   : response valid, may rise in the same cycle as imem_req
//   imem_rdata : instruction word, meaningful only while imem_ack=1
//   master = fetch stage side, slave = instruction memory side.
// ---------------------------------------------------------------------------
interface fetch_stage_if #(
  parameter int PC_W = 9
);

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage. Owns the program counter, issues requests on the
//   instruction-memory bus and loads the IF/ID pipeline register. A taken
//   branch from EX (PcSel/BrPC) redirects the PC and flushes wrong-path work;
//   the hazard unit's Stall holds the IF/ID register.
//
//   clk        : rising-edge clock
//   reset      : asynchronous, active-high reset
//   PcSel      : redirect request (branch taken in EX this cycle)
//   BrPC       : redirect target, low two bits ignored
//   Stall      : hold IF/ID contents
//   imem       : instruction-memory bus (master side)
//   IfId_PC    : PC of the instruction in IF/ID
//   IfId_Instr : instruction in IF/ID (NOP when bubble)
//   IfId_Valid : IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PcSel,
  input  logic [31:0]      BrPC,
  input  logic             Stall,
  fetch_stage_if.master    imem,
  output logic [PC_W-1:0]  IfId_PC,
  output logic [31:0]      IfId_Instr,
  output logic             IfId_Valid
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] drainAddr_q, drainAddr_d;
  logic [PC_W-1:0] holdPc_q, holdPc_d;
  logic [31:0]     holdInstr_q, holdInstr_d;
  logic [PC_W-1:0] ifIdPc_q, ifIdPc_d;
  logic [31:0]     ifIdInstr_q, ifIdInstr_d;
  logic            ifIdValid_q, ifIdValid_d;

  logic [PC_W-1:0] brTarget;
  logic            unusedBrBits;

  // Branch targets are word aligned; only the PC-sized slice of BrPC matters.
  assign brTarget     = {BrPC[PC_W-1:2], 2'b00};
  assign unusedBrBits = ^{BrPC[31:PC_W], BrPC[1:0]};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A redirect always wins. Leaving REQ on a redirect
  // without an ack must first drain the abandoned request, because the memory
  // still owes us a response for the old address. In DRAIN an ack returns us
  // to REQ even if another redirect arrives in the same cycle, otherwise we
  // would wait forever for a second response that never comes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (PcSel) begin
          state_d = imem.imem_ack ? REQ : DRAIN;
        end else if (imem.imem_ack && Stall) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (PcSel || !Stall) begin
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (imem.imem_ack) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs. The address comes from the latched drain address while an
  // abandoned request is outstanding so it never changes mid-request, even
  // though the PC has already moved to the branch target.
  always_comb begin
    imem.imem_req  = (state_q == REQ) || (state_q == DRAIN);
    imem.imem_addr = (state_q == DRAIN) ? drainAddr_q : pc_q;
  end

  // Datapath next-state: PC, hold buffer, drain address and IF/ID. A fetch
  // that completes under Stall is parked in the hold buffer so the memory
  // handshake can finish without overwriting the stalled IF/ID contents.
  // The redirect overrides are applied last so they win over everything.
  always_comb begin
    pc_d        = pc_q;
    drainAddr_d = drainAddr_q;
    holdPc_d    = holdPc_q;
    holdInstr_d = holdInstr_q;
    ifIdPc_d    = ifIdPc_q;
    ifIdInstr_d = ifIdInstr_q;
    ifIdValid_d = ifIdValid_q;

    case (state_q)
      REQ: begin
        if (imem.imem_ack) begin
          pc_d = pc_q + PC_W'(4);
          if (Stall) begin
            holdPc_d    = pc_q;
            holdInstr_d = imem.imem_rdata;
          end else begin
            ifIdPc_d    = pc_q;
            ifIdInstr_d = imem.imem_rdata;
            ifIdValid_d = 1'b1;
          end
        end else if (!Stall) begin
          ifIdInstr_d = NOP_INSTR;
          ifIdValid_d = 1'b0;
        end
      end
      HOLD: begin
        if (!Stall) begin
          ifIdPc_d    = holdPc_q;
          ifIdInstr_d = holdInstr_q;
          ifIdValid_d = 1'b1;
        end
      end
      default: begin
        if (!Stall) begin
          ifIdInstr_d = NOP_INSTR;
          ifIdValid_d = 1'b0;
        end
      end
    endcase

    if (PcSel) begin
      pc_d        = brTarget;
      ifIdInstr_d = NOP_INSTR;
      ifIdValid_d = 1'b0;
      if (state_q == REQ) begin
        drainAddr_d = pc_q;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      drainAddr_q <= '0;
      holdPc_q    <= '0;
      holdInstr_q <= NOP_INSTR;
      ifIdPc_q    <= '0;
      ifIdInstr_q <= NOP_INSTR;
      ifIdValid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      drainAddr_q <= drainAddr_d;
      holdPc_q    <= holdPc_d;
      holdInstr_q <= holdInstr_d;
      ifIdPc_q    <= ifIdPc_d;
      ifIdInstr_q <= ifIdInstr_d;
      ifIdValid_q <= ifIdValid_d;
    end
  end

  // IF/ID register outputs.
  always_comb begin
    IfId_PC    = ifIdPc_q;
    IfId_Instr = ifIdInstr_q;
    IfId_Valid = ifIdValid_q;
  end

endmodule
